// File: rtl/cnn_mac_pipe_if.sv
// Stream bundle for cnn_mac_pipe: operand beats in, packet sums out.
// Each direction has its own valid/ready pair.
interface cnn_mac_pipe_if #(
    parameter int DIN0_WIDTH = 8,
    parameter int DIN1_WIDTH = 14,
    parameter int DOUT_WIDTH = 22
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DIN0_WIDTH-1:0] din0;
    logic signed [DIN1_WIDTH-1:0] din1;
    logic                         in_first;
    logic                         in_last;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DOUT_WIDTH-1:0] dout;
    logic                         dout_sat;

    // MAC side: consumes beats, produces results
    modport slave (
        input  in_valid, din0, din1, in_first, in_last, out_ready,
        output in_ready, out_valid, dout, dout_sat
    );

    // Producer/consumer side: drives beats, takes results
    modport master (
        output in_valid, din0, din1, in_first, in_last, out_ready,
        input  in_ready, out_valid, dout, dout_sat
    );
endinterface

// File: rtl/cnn_mac_pipe.sv
// Pipelined signed multiply-accumulate for the CNN convolution datapath.
// Beats carry their first/last flags down a MUL_STAGES-deep product pipe.
// The accumulate stage sums a packet, and the packet's last beat loads a
// saturated or truncated result behind a valid/ready output register.
// A single clock-enable (output empty or being taken) stalls the whole pipe.
// MUL_STAGES must be in 1..4, ACC_WIDTH >= DIN0_WIDTH+DIN1_WIDTH, and
// DOUT_WIDTH <= ACC_WIDTH.
module cnn_mac_pipe #(
    parameter int DIN0_WIDTH = 8,
    parameter int DIN1_WIDTH = 14,
    parameter int ACC_WIDTH  = 32,
    parameter int DOUT_WIDTH = 22,
    parameter int MUL_STAGES = 2,
    parameter int SAT_EN     = 1
) (
    input  logic           ap_clk,
    input  logic           ap_rst_n,
    cnn_mac_pipe_if.slave  mac
);
    localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;
    localparam int LAST       = MUL_STAGES - 1;

    // Clip bounds of the output range, expressed at accumulator width
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    localparam logic signed [DOUT_WIDTH-1:0] DOUT_MAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [DOUT_WIDTH-1:0] DOUT_MIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

    logic                         w_ce;
    logic signed [PROD_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]  w_prod_ext;
    logic signed [ACC_WIDTH-1:0]  w_acc_next;
    logic signed [DOUT_WIDTH-1:0] w_dout;
    logic                         w_sat;
    logic                         w_emit;

    logic [MUL_STAGES-1:0]        r_vld;
    logic [MUL_STAGES-1:0]        r_first;
    logic [MUL_STAGES-1:0]        r_last;
    logic signed [PROD_WIDTH-1:0] r_prod [MUL_STAGES];
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic                         r_out_valid;
    logic signed [DOUT_WIDTH-1:0] r_dout;
    logic                         r_dout_sat;

    assign w_ce         = !r_out_valid || mac.out_ready;
    assign mac.in_ready = w_ce;

    // Full-precision signed product of the incoming operands
    assign w_prod = PROD_WIDTH'(mac.din0) * PROD_WIDTH'(mac.din1);

    // Product pipe: beats and their flags move one stage per enabled cycle
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_vld   <= '0;
            r_first <= '0;
            r_last  <= '0;
            for (int unsigned i = 0; i < MUL_STAGES; i++) begin
                r_prod[i] <= '0;
            end
        end else if (w_ce) begin
            r_vld[0]   <= mac.in_valid;
            r_first[0] <= mac.in_first;
            r_last[0]  <= mac.in_last;
            r_prod[0]  <= w_prod;
            for (int unsigned i = 1; i < MUL_STAGES; i++) begin
                r_vld[i]   <= r_vld[i-1];
                r_first[i] <= r_first[i-1];
                r_last[i]  <= r_last[i-1];
                r_prod[i]  <= r_prod[i-1];
            end
        end
    end

    assign w_prod_ext = ACC_WIDTH'(r_prod[LAST]);
    assign w_acc_next = r_first[LAST] ? w_prod_ext : r_acc + w_prod_ext;
    assign w_emit     = r_vld[LAST] && r_last[LAST];

    // Narrow the running sum to the output width, clipping when enabled
    always_comb begin
        w_dout = w_acc_next[DOUT_WIDTH-1:0];
        w_sat  = 1'b0;
        if (SAT_EN != 0) begin
            if (w_acc_next > SAT_MAX) begin
                w_dout = DOUT_MAX;
                w_sat  = 1'b1;
            end else if (w_acc_next < SAT_MIN) begin
                w_dout = DOUT_MIN;
                w_sat  = 1'b1;
            end
        end
    end

    // Accumulator: only valid beats update it, bubbles leave it untouched
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_acc <= '0;
        end else if (w_ce && r_vld[LAST]) begin
            r_acc <= w_acc_next;
        end
    end

    // Output register: load on a last beat, otherwise drain once taken
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_dout_sat  <= 1'b0;
        end else if (w_ce) begin
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_dout      <= w_dout;
                r_dout_sat  <= w_sat;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign mac.out_valid = r_out_valid;
    assign mac.dout      = r_dout;
    assign mac.dout_sat  = r_dout_sat;
endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Directed bench for cnn_mac_pipe (defaults: 8s x 14s, ACC 32, DOUT 22,
// two stages, saturation on). Results are collected at the falling edge
// whenever the output handshake will complete on the next rising edge.
module tb_cnn_mac_pipe;
    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [21:0] q_dout [$];
    logic               q_sat  [$];

    int bp_a   [8] = '{1, -2, 3, -4, 5, -6, 7, -8};
    int bp_b   [8] = '{10, 20, 30, 40, 50, 60, 70, 80};
    int bp_exp [8] = '{10, -40, 90, -160, 250, -360, 490, -640};

    cnn_mac_pipe_if #(.DIN0_WIDTH(8), .DIN1_WIDTH(14), .DOUT_WIDTH(22)) mac_if ();

    cnn_mac_pipe #(
        .DIN0_WIDTH (8),
        .DIN1_WIDTH (14),
        .ACC_WIDTH  (32),
        .DOUT_WIDTH (22),
        .MUL_STAGES (2),
        .SAT_EN     (1)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .mac      (mac_if)
    );

    always #5 ap_clk = ~ap_clk;

    // Capture every result that the consumer takes on the coming edge
    always @(negedge ap_clk) begin
        if (ap_rst_n && mac_if.out_valid && mac_if.out_ready) begin
            q_dout.push_back(mac_if.dout);
            q_sat.push_back(mac_if.dout_sat);
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one beat and hold it until the DUT has accepted it
    task automatic send(input int a, input int b, input bit f, input bit l);
        bit ok = 1'b0;
        mac_if.in_valid = 1'b1;
        mac_if.din0     = 8'(a);
        mac_if.din1     = 14'(b);
        mac_if.in_first = f;
        mac_if.in_last  = l;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge ap_clk);
            ok = mac_if.in_ready;
            @(posedge ap_clk);
            #1;
        end
        if (!ok) check("send_accept", ok, 1);
    endtask

    task automatic idle(input int n);
        mac_if.in_valid = 1'b0;
        repeat (n) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic wait_result(input string tag, input longint exp_dout, input longint exp_sat);
        int n = 0;
        while (q_dout.size() == 0 && n < 100) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
        check({tag, "_arrived"}, (q_dout.size() > 0), 1);
        if (q_dout.size() > 0) begin
            check({tag, "_dout"}, q_dout.pop_front(), exp_dout);
            check({tag, "_sat"},  q_sat.pop_front(),  exp_sat);
        end
    endtask

    task automatic flush_results();
        q_dout.delete();
        q_sat.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint held;
        mac_if.in_valid  = 1'b0;
        mac_if.din0      = '0;
        mac_if.din1      = '0;
        mac_if.in_first  = 1'b0;
        mac_if.in_last   = 1'b0;
        mac_if.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_out_valid", mac_if.out_valid, 0);
        check("rst_dout",      mac_if.dout,      0);
        check("rst_dout_sat",  mac_if.dout_sat,  0);
        check("rst_in_ready",  mac_if.in_ready,  1);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        // Single beat with latency: valid two edges after the accept edge
        mac_if.in_valid = 1'b1;
        mac_if.din0     = -8'sd3;
        mac_if.din1     = 14'sd100;
        mac_if.in_first = 1'b1;
        mac_if.in_last  = 1'b1;
        @(posedge ap_clk);
        #1;
        mac_if.in_valid = 1'b0;
        check("lat_e0_valid", mac_if.out_valid, 0);
        @(posedge ap_clk);
        #1;
        check("lat_e1_valid", mac_if.out_valid, 0);
        @(posedge ap_clk);
        #1;
        check("lat_e2_valid", mac_if.out_valid, 1);
        check("single_dout",  mac_if.dout,      -300);
        check("single_sat",   mac_if.dout_sat,  0);
        idle(2);
        flush_results();

        // Three-beat packet
        send(2, 10, 1'b1, 1'b0);
        send(-5, 7, 1'b0, 1'b0);
        send(127, 8191, 1'b0, 1'b1);
        idle(1);
        wait_result("pkt3", 1040242, 0);

        // Positive saturation
        send(-128, -8192, 1'b1, 1'b0);
        send(-128, -8192, 1'b0, 1'b1);
        idle(1);
        wait_result("satpos", 2097151, 1);

        // Negative saturation
        send(-128, 8191, 1'b1, 1'b0);
        send(-128, 8191, 1'b0, 1'b0);
        send(-128, 8191, 1'b0, 1'b1);
        idle(1);
        wait_result("satneg", -2097152, 1);
        idle(3);
        flush_results();

        // Backpressure: consumer stalls for five edges mid-stream
        fork
            begin
                for (int i = 0; i < 8; i++) send(bp_a[i], bp_b[i], 1'b1, 1'b1);
                idle(1);
            end
            begin
                repeat (3) @(posedge ap_clk);
                #1;
                mac_if.out_ready = 1'b0;
                held = mac_if.dout;
                check("bp_full_valid", mac_if.out_valid, 1);
                check("bp_held_first", held, 10);
                for (int k = 0; k < 5; k++) begin
                    @(posedge ap_clk);
                    #1;
                    check("bp_hold_valid",    mac_if.out_valid, 1);
                    check("bp_hold_in_ready", mac_if.in_ready,  0);
                    check("bp_hold_dout",     mac_if.dout,      held);
                end
                mac_if.out_ready = 1'b1;
            end
        join
        for (int i = 0; i < 8; i++) wait_result($sformatf("bp%0d", i), bp_exp[i], 0);
        idle(3);
        flush_results();

        // Three-beat packet with bubbles between beats
        send(2, 10, 1'b1, 1'b0);
        idle($urandom_range(1, 3));
        send(-5, 7, 1'b0, 1'b0);
        idle($urandom_range(1, 3));
        send(127, 8191, 1'b0, 1'b1);
        idle(1);
        wait_result("bubble", 1040242, 0);
        idle(3);
        flush_results();

        // Reset in the middle of a packet while a result is held
        send(3, 3, 1'b1, 1'b1);
        send(2, 10, 1'b1, 1'b0);
        send(-5, 7, 1'b0, 1'b0);
        mac_if.out_ready = 1'b0;
        mac_if.in_valid  = 1'b0;
        check("midrst_pre_valid", mac_if.out_valid, 1);
        check("midrst_pre_dout",  mac_if.dout,      9);
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("midrst_valid",    mac_if.out_valid, 0);
        check("midrst_dout",     mac_if.dout,      0);
        check("midrst_in_ready", mac_if.in_ready,  1);
        flush_results();
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        mac_if.out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        send(4, 5, 1'b1, 1'b1);
        idle(1);
        wait_result("post_rst", 20, 0);

        // Packet without a first flag adds onto the residual sum
        send(1, 1, 1'b0, 1'b1);
        idle(1);
        wait_result("no_first", 21, 0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cnn_mac_pipe.md
# cnn_mac_pipe

Pipelined, parametrised signed multiply-accumulate unit for the CNN convolution datapath. It succeeds the fixed-width 8s×14s combinational DSP multiplier. It multiplies a streamed pixel operand by a streamed weight operand over a configurable number of register stages and accumulates products across a packet delimited by first/last flags. Each packet's sum is emitted once, saturated or truncated to the output width, behind a valid/ready handshake with full backpressure. It sits between the line-buffer/weight-fetch logic and the conv output writer.

## Interface
- DIN0_WIDTH, 8: signed width of din0 (pixel).
- DIN1_WIDTH, 14: signed width of din1 (weight).
- ACC_WIDTH, 32: accumulator width; must be ≥ DIN0_WIDTH+DIN1_WIDTH.
- DOUT_WIDTH, 22: result width; must be ≤ ACC_WIDTH.
- MUL_STAGES, 2: product pipeline register stages, legal range 1..4.
- SAT_EN, 1: 1 = saturate the result to DOUT_WIDTH; 0 = truncate to the low DOUT_WIDTH bits.

Ports:
- ap_clk  in  1  single clock; all logic is rising-edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit accepts a beat this cycle.
- din0  in  DIN0_WIDTH  signed operand A.
- din1  in  DIN1_WIDTH  signed operand B.
- in_first  in  1  beat starts a new packet sum.
- in_last  in  1  beat ends the packet; its sum is emitted.
- out_valid  out  1  dout holds a packet result.
- out_ready  in  1  consumer takes the result.
- dout  out  DOUT_WIDTH  signed packet result.
- dout_sat  out  1  result was clipped (always 0 when SAT_EN=0).

## Operation
- Accept: a beat is taken when in_valid && in_ready. din0, din1, in_first and in_last travel together through the stages.
- Stall: ce = !out_valid || out_ready, and in_ready = ce. All stage registers, the accumulator and the output advance only when ce=1. A stall freezes everything and drops nothing.
- Stage valid bits: each stage carries a valid bit. Bubbles (in_valid=0) never modify the accumulator.
- Product: full-precision signed product of DIN0_WIDTH+DIN1_WIDTH bits, sign-extended to ACC_WIDTH.
- Accumulate: for a valid beat reaching the accumulate stage, acc_next = in_first ? prod : acc + prod. The sum wraps modulo 2^ACC_WIDTH and acc <= acc_next.
- first and last together: a beat with both flags set emits that single product.
- Missing first: a packet that starts without in_first accumulates onto the residual acc (0 after reset).
- Emit: if the beat has in_last, the output register loads result(acc_next) and out_valid is set. In the same cycle acc <= acc_next.
- Saturation (SAT_EN=1):
  - acc_next > 2^(DOUT_WIDTH-1)-1 → dout = max, dout_sat = 1.
  - acc_next < -2^(DOUT_WIDTH-1) → dout = min, dout_sat = 1.
  - Otherwise dout = low bits, dout_sat = 0.
- Truncation (SAT_EN=0): dout = acc_next[DOUT_WIDTH-1:0], dout_sat = 0.
- Output hold: out_valid, dout and dout_sat stay stable until out_ready=1.
  - On out_ready=1, a new result may load in the same edge (back-to-back results).
  - Otherwise out_valid clears.

## Timing
- Reset, asynchronous and active-low, takes effect immediately: all stage valid bits = 0, acc = 0, out_valid = 0, dout = 0, dout_sat = 0.
- in_ready is combinational from out_valid/out_ready. It reads 1 during reset release and whenever the output is empty.
- Latency: a last beat accepted at edge E produces out_valid=1 after edge E+MUL_STAGES. With the default MUL_STAGES=2, that is 2 cycles.
- Throughput: one beat per cycle with out_ready held high. Single-beat packets give one result per cycle.
- Backpressure: when out_valid=1 and out_ready=0, in_ready=0 in that cycle and the pipeline contents are preserved exactly.
- Reset mid-packet: partial sums and in-flight beats are discarded. The first beat after reset must carry in_first for a clean sum.
- Simultaneous events: a last beat reaching the accumulate stage while the output is taken (out_ready=1) loads the new result on that edge, with no bubble.

## Test plan
- Single beat: (din0=-3, din1=100, first=last=1) → dout=-300, dout_sat=0, out_valid 2 cycles after the accept edge.
- Three-beat packet, (2,10), (-5,7), (127,8191), with first on beat 1 and last on beat 3 → dout=1040242, dout_sat=0.
- Positive saturation: two beats of (-128,-8192) → dout=2097151, dout_sat=1.
- Negative saturation: three beats of (-128,8191) → dout=-2097152, dout_sat=1.
- Backpressure: 8 back-to-back single-beat packets with out_ready low for 5 cycles mid-stream.
  - in_ready drops while the output is full.
  - dout stays stable while held.
  - All 8 results arrive in order with correct values.
- Bubbles and reset: repeat the three-beat packet with random in_valid gaps → still 1040242.
  - Then assert ap_rst_n low after beat 2 of a packet → out_valid=0 immediately.
  - A following fresh packet (4,5, first/last) → dout=20.
